date_time_counter: RTL and testbench
====================================

DATE_TIME_COUNTER -- requirements
Module: date_time_counter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: tick  input  1  one-second update request (time-update "u" strobe), single-cycle pulse.
REQ-004 SHALL have port: enable  input  1  1 = counting allowed; 0 = ticks ignored, loads still accepted.
REQ-005 SHALL have port: load  input  1  write load_data into the field chosen by load_sel.
REQ-006 SHALL have port: load_sel  input  3  0 sec, 1 min, 2 hour, 3 date, 4 month, 5 day, 6 year, 7 reserved (no write).
REQ-007 SHALL have port: load_data  input  6  databus value; upper bits beyond field width SHALL be ignored.
REQ-008 SHALL have outputs sec[5:0], min[5:0], hour[4:0], date[4:0], month[3:0], day[2:0], year[5:0], all registered.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a completed tick update.
REQ-010 SHALL have port: day_roll  output  1  one-cycle pulse when hour wraps 23->0.
REQ-011 SHALL have port: load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-012 Field ranges SHALL be: sec 0-59, min 0-59, hour 0-23, date 1-dim, month 1-12, day 0-6 (0 = Sunday), year 0-63 (offset from 2000).
REQ-013 dim SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 when year[1:0]==0; otherwise 28.
REQ-014 On tick=1, enable=1, load=0, the full carry chain SHALL resolve in one edge: sec increments; carries propagate sec->min->hour->(date, day)->month->year.
REQ-015 Wraps SHALL be: sec 59->0, min 59->0, hour 23->0, date dim->1, month 12->1, day 6->0, year 63->0.
REQ-016 day SHALL advance exactly when date advances or wraps.
REQ-017 done SHALL be 1 for exactly the cycle following each accepted tick; it SHALL be 0 otherwise.
REQ-018 day_roll SHALL be 1 for exactly the cycle following an accepted tick that wraps hour.
REQ-019 A tick with enable=0 SHALL change no field and SHALL produce no done.
REQ-020 A load with in-range data SHALL write only the selected field on the next edge; all other fields SHALL hold.
REQ-021 Out-of-range loads SHALL be rejected: field unchanged, load_err=1 for one cycle. Out-of-range means sec/min >59, hour >23, date 0 or >dim of the current month/year, month 0 or >12, day 7, or load_sel=7.
REQ-022 A legal month or year load that makes the current date exceed the new dim SHALL clamp date to the new dim on the same edge.
REQ-023 When load and tick coincide, the load SHALL win, the tick SHALL be dropped, and done SHALL not pulse.
REQ-024 Back-to-back ticks on consecutive cycles SHALL each be applied; there SHALL be no tick buffering beyond one cycle.
REQ-025 tick widths longer than one cycle SHALL be edge-detected: one increment per rising edge of tick.

Reset
REQ-026 clear_n=0 SHALL immediately force sec=0, min=0, hour=0, date=1, month=1, day=6 (Saturday 01-Jan-2000), year=0, done=0, day_roll=0, load_err=0, and clear the tick edge detector.
REQ-027 Reset asserted mid-update SHALL discard the update; the first tick after release SHALL be counted only on a fresh rising edge.

Verification
REQ-028 Reset release, one tick -> sec=1, all other fields at reset values, done pulses one cycle, day_roll=0.
REQ-029 Load 23:59:59 on 31-Dec year 63 with day=3, then tick -> 00:00:00 on 01-Jan year 0 with day=4; done=1 and day_roll=1.
REQ-030 Load 28-Feb year 4 23:59:59, tick -> 29-Feb. Repeat with year 5 -> 01-Mar.
REQ-031 With month=4, load date 31 -> load_err=1 and date unchanged. With date=31 and month=1, load month=2 in year 5 -> month=2, date=28.
REQ-032 load (sec=10) and tick in the same cycle -> sec=10, done=0. Next tick -> sec=11.
REQ-033 enable=0 with 5 ticks -> no change. Assert clear_n low between ticks -> immediate reset values; a tick held high across release -> no increment.

Source files
------------

// File: rtl/date_time_counter_if.sv
// Control and field bus of the calendar/clock counter.
// The slave side is the counter itself; the master side drives ticks and loads.
interface date_time_counter_if;
    logic       tick;
    logic       enable;
    logic       load;
    logic [2:0] load_sel;
    logic [5:0] load_data;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] date;
    logic [3:0] month;
    logic [2:0] day;
    logic [5:0] year;
    logic       done;
    logic       day_roll;
    logic       load_err;

    modport slave (
        input  tick, enable, load, load_sel, load_data,
        output sec, min, hour, date, month, day, year, done, day_roll, load_err
    );

    modport master (
        output tick, enable, load, load_sel, load_data,
        input  sec, min, hour, date, month, day, year, done, day_roll, load_err
    );
endinterface

// File: rtl/date_time_counter.sv
// Seconds-to-year calendar counter (years 2000-2063) with field loads,
// single-edge carry resolution and a rising-edge tick detector.
module date_time_counter (
    input  logic                 clk,
    input  logic                 clear_n,
    date_time_counter_if.slave   bus
);
    logic [5:0] sec_q,   sec_d;
    logic [5:0] min_q,   min_d;
    logic [4:0] hour_q,  hour_d;
    logic [4:0] date_q,  date_d;
    logic [3:0] month_q, month_d;
    logic [2:0] day_q,   day_d;
    logic [5:0] year_q,  year_d;
    logic       tick_prev_q;
    logic       done_q,  done_d;
    logic       roll_q,  roll_d;
    logic       err_q,   err_d;

    logic       tick_acc;
    logic [4:0] dim_cur;
    logic [4:0] dim_ld;
    logic [5:0] ld;

    function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [5:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim_f = 5'd30;
            4'd2:                    dim_f = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 dim_f = 5'd31;
        endcase
    endfunction

    assign ld       = bus.load_data;
    assign dim_cur  = dim_f(month_q, year_q);
    assign tick_acc = bus.tick & ~tick_prev_q & bus.enable & ~bus.load;

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        date_d  = date_q;
        month_d = month_q;
        day_d   = day_q;
        year_d  = year_q;
        dim_ld  = dim_cur;
        done_d  = 1'b0;
        roll_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            case (bus.load_sel)
                3'd0: if (ld < 6'd60) sec_d = ld; else err_d = 1'b1;
                3'd1: if (ld < 6'd60) min_d = ld; else err_d = 1'b1;
                3'd2: if (ld[4:0] < 5'd24) hour_d = ld[4:0]; else err_d = 1'b1;
                3'd3: if (ld[4:0] != 5'd0 && ld[4:0] <= dim_cur) date_d = ld[4:0];
                      else err_d = 1'b1;
                3'd4: begin
                    // Month change may shorten the month: clamp date on the same edge.
                    if (ld[3:0] != 4'd0 && ld[3:0] <= 4'd12) begin
                        month_d = ld[3:0];
                        dim_ld  = dim_f(ld[3:0], year_q);
                        if (date_q > dim_ld) date_d = dim_ld;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                3'd5: if (ld[2:0] != 3'd7) day_d = ld[2:0]; else err_d = 1'b1;
                3'd6: begin
                    year_d = ld;
                    dim_ld = dim_f(month_q, ld);
                    if (date_q > dim_ld) date_d = dim_ld;
                end
                default: err_d = 1'b1;
            endcase
        end else if (tick_acc) begin
            done_d = 1'b1;
            if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
            else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) min_d = min_q + 6'd1;
                else begin
                    min_d = 6'd0;
                    if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
                    else begin
                        hour_d = 5'd0;
                        roll_d = 1'b1;
                        day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
                        if (date_q < dim_cur) date_d = date_q + 5'd1;
                        else begin
                            date_d = 5'd1;
                            if (month_q != 4'd12) month_d = month_q + 4'd1;
                            else begin
                                month_d = 4'd1;
                                year_d  = year_q + 6'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Detector resets to "seen high" so a tick held across reset release is not counted.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            date_q      <= 5'd1;
            month_q     <= 4'd1;
            day_q       <= 3'd6;
            year_q      <= 6'd0;
            tick_prev_q <= 1'b1;
            done_q      <= 1'b0;
            roll_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            date_q      <= date_d;
            month_q     <= month_d;
            day_q       <= day_d;
            year_q      <= year_d;
            tick_prev_q <= bus.tick;
            done_q      <= done_d;
            roll_q      <= roll_d;
            err_q       <= err_d;
        end
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.date     = date_q;
    assign bus.month    = month_q;
    assign bus.day      = day_q;
    assign bus.year     = year_q;
    assign bus.done     = done_q;
    assign bus.day_roll = roll_q;
    assign bus.load_err = err_q;
endmodule

// File: tb/tb_date_time_counter.sv
// Directed plus randomized checks of date_time_counter against a calendar
// model built on seconds-of-day arithmetic and a month-length table.
module tb_date_time_counter;
    logic clk = 1'b0;
    logic clear_n;
    int   tests = 0;
    int   fails = 0;

    date_time_counter_if bus();
    date_time_counter dut (.clk(clk), .clear_n(clear_n), .bus(bus));

    always #5 clk = ~clk;

    int m_sec, m_min, m_hour, m_date, m_month, m_day, m_year;
    bit m_tprev, e_done, e_roll, e_err;
    int mdays_tab [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int mdays(input int m, input int y);
        return (m == 2 && y % 4 == 0) ? 29 : mdays_tab[m - 1];
    endfunction

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hour = 0; m_date = 1; m_month = 1; m_day = 6; m_year = 0;
        m_tprev = 1'b1; e_done = 1'b0; e_roll = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_tick();
        int t;
        t = m_hour * 3600 + m_min * 60 + m_sec + 1;
        m_sec = t % 60; m_min = (t / 60) % 60; m_hour = (t / 3600) % 24;
        if (t == 86400) begin
            e_roll = 1'b1;
            m_day  = (m_day + 1) % 7;
            m_date++;
            if (m_date > mdays(m_month, m_year)) begin
                m_date = 1;
                m_month++;
                if (m_month > 12) begin m_month = 1; m_year = (m_year + 1) % 64; end
            end
        end
    endtask

    task automatic model_load(input int sel, input int data);
        int v;
        case (sel)
            0: if (data < 60) m_sec = data; else e_err = 1'b1;
            1: if (data < 60) m_min = data; else e_err = 1'b1;
            2: begin v = data % 32; if (v < 24) m_hour = v; else e_err = 1'b1; end
            3: begin v = data % 32; if (v >= 1 && v <= mdays(m_month, m_year)) m_date = v; else e_err = 1'b1; end
            4: begin
                v = data % 16;
                if (v >= 1 && v <= 12) begin
                    m_month = v;
                    if (m_date > mdays(m_month, m_year)) m_date = mdays(m_month, m_year);
                end else e_err = 1'b1;
            end
            5: begin v = data % 8; if (v != 7) m_day = v; else e_err = 1'b1; end
            6: begin
                m_year = data % 64;
                if (m_date > mdays(m_month, m_year)) m_date = mdays(m_month, m_year);
            end
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sec"},      32'(bus.sec),      m_sec);
        chk({tag, ".min"},      32'(bus.min),      m_min);
        chk({tag, ".hour"},     32'(bus.hour),     m_hour);
        chk({tag, ".date"},     32'(bus.date),     m_date);
        chk({tag, ".month"},    32'(bus.month),    m_month);
        chk({tag, ".day"},      32'(bus.day),      m_day);
        chk({tag, ".year"},     32'(bus.year),     m_year);
        chk({tag, ".done"},     32'(bus.done),     32'(e_done));
        chk({tag, ".day_roll"}, 32'(bus.day_roll), 32'(e_roll));
        chk({tag, ".load_err"}, 32'(bus.load_err), 32'(e_err));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input bit t, input bit en, input bit ld,
                        input int sel, input int data);
        bit rise;
        bus.tick      = t;
        bus.enable    = en;
        bus.load      = ld;
        bus.load_sel  = sel[2:0];
        bus.load_data = data[5:0];
        rise    = t && !m_tprev;
        m_tprev = t;
        e_done = 1'b0; e_roll = 1'b0; e_err = 1'b0;
        if (ld) model_load(sel, data);
        else if (rise && en) begin e_done = 1'b1; model_tick(); end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic ld(input string tag, input int sel, input int data);
        step(tag, 1'b0, 1'b1, 1'b1, sel, data);
    endtask

    task automatic tk(input string tag);
        step({tag, ".hi"}, 1'b1, 1'b1, 1'b0, 0, 0);
        step({tag, ".lo"}, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        clear_n = 1'b0;
        bus.tick = 1'b0; bus.enable = 1'b1; bus.load = 1'b0;
        bus.load_sel = 3'd0; bus.load_data = 6'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        clear_n = 1'b1;
        step("idle", 1'b0, 1'b1, 1'b0, 0, 0);
        tk("first_tick");

        // Year-63 New Year's Eve rollover
        ld("y63", 6, 63); ld("m12", 4, 12); ld("d31", 3, 31); ld("dow3", 5, 3);
        ld("h23", 2, 23); ld("mi59", 1, 59); ld("s59", 0, 59);
        tk("nye");

        // Leap / non-leap February
        ld("y4", 6, 4); ld("feb", 4, 2); ld("d28", 3, 28);
        ld("h23b", 2, 23); ld("mi59b", 1, 59); ld("s59b", 0, 59);
        tk("leap");
        ld("y5clamp", 6, 5); ld("d28c", 3, 28);
        ld("h23c", 2, 23); ld("mi59c", 1, 59); ld("s59c", 0, 59);
        tk("nonleap");

        // Date range and month clamp
        ld("apr", 4, 4); ld("apr31", 3, 31);
        ld("jan", 4, 1); ld("jan31", 3, 31); ld("y5", 6, 5); ld("febclamp", 4, 2);

        // Load beats coincident tick
        step("ld_tick", 1'b1, 1'b1, 1'b1, 0, 10);
        step("ld_tick.lo", 1'b0, 1'b1, 1'b0, 0, 0);
        tk("after_ld");

        // Rejections and truncated data bus
        ld("sel7", 7, 5); ld("sec60", 0, 60); ld("min63", 1, 63); ld("hour24", 2, 24);
        ld("hour_trunc", 2, 37); ld("mon_trunc", 4, 'h31); ld("mon0", 4, 0);
        ld("mon13", 4, 13); ld("day7", 5, 7); ld("date0", 3, 0);

        // Ticks ignored while disabled
        for (int i = 0; i < 5; i++) begin
            step("dis.hi", 1'b1, 1'b0, 1'b0, 0, 0);
            step("dis.lo", 1'b0, 1'b0, 1'b0, 0, 0);
        end

        // Held tick counts once; alternating pulses each count
        for (int i = 0; i < 3; i++) step("held", 1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step("alt", i[0] == 1'b0, 1'b1, 1'b0, 0, 0);

        // Reset mid-run, tick held across release
        step("pre_rst", 1'b1, 1'b1, 1'b0, 0, 0);
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2;
        clear_n = 1'b1;
        step("held_rel1", 1'b1, 1'b1, 1'b0, 0, 0);
        step("held_rel2", 1'b1, 1'b1, 1'b0, 0, 0);
        step("rel_lo", 1'b0, 1'b1, 1'b0, 0, 0);
        tk("fresh");

        // Randomized traffic starting near a day boundary
        ld("r_h", 2, 23); ld("r_m", 1, 59); ld("r_s", 0, 50);
        for (int i = 0; i < 400; i++) begin
            bit t, en, l;
            t  = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 9) == 0);
            step($sformatf("rnd%0d", i), t, en, l, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 63)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
